proj1_ctrl: RTL and testbench

Multicycle control unit for the proj1 accumulator CPU. It sits directly upstream of the datapath and the 256x16 RAM. It sequences fetch, decode and execute through a 13-state Moore FSM and drives every datapath load/select strobe plus the memory read/write line. The FSM state is exposed so benches can trace execution by state number.

---
 rtl/proj1_ctrl_if.sv | 41 ++++
 rtl/proj1_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_proj1_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/proj1_ctrl_if.sv
// proj1_ctrl_if: control bus between the proj1 controller and its datapath/RAM.
//   opcode      : IR[15:12] from datapath to controller
//   state_reg   : current controller state number
//   mar_*/mdr_* : MAR/MDR load strobes and input selects
//   mem_rw      : RAM read (0) / write (1)
//   pc_inc/pc_load, ir_load, acc_load, alu_op : datapath register strobes
//   instr_count : retired-instruction counter
//   illegal_op  : sticky undefined-opcode flag
// master = controller side, slave = datapath side.
interface proj1_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       opcode;
    logic [3:0]       state_reg;
    logic             mar_load;
    logic             mar_sel;
    logic             mdr_load;
    logic             mdr_sel;
    logic             mem_rw;
    logic             pc_inc;
    logic             pc_load;
    logic             ir_load;
    logic             acc_load;
    logic [1:0]       alu_op;
    logic [CNT_W-1:0] instr_count;
    logic             illegal_op;

    modport master (
        input  opcode,
        output state_reg, mar_load, mar_sel, mdr_load, mdr_sel, mem_rw,
               pc_inc, pc_load, ir_load, acc_load, alu_op,
               instr_count, illegal_op
    );

    modport slave (
        output opcode,
        input  state_reg, mar_load, mar_sel, mdr_load, mdr_sel, mem_rw,
               pc_inc, pc_load, ir_load, acc_load, alu_op,
               instr_count, illegal_op
    );
endinterface

// File: rtl/proj1_ctrl.sv
// proj1_ctrl: multicycle fetch/decode/execute controller for the proj1
// accumulator CPU, 13-state Moore FSM.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : proj1_ctrl_if.master -- opcode in; state, datapath strobes,
//          mem_rw, instr_count and illegal_op out.
// Strobes are registered from the decode of the next state, so they always
// equal the decode of state_reg while adding no output logic after the flops.
module proj1_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    proj1_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH_1     = 4'd0,
        S_FETCH_2     = 4'd1,
        S_FETCH_3     = 4'd2,
        S_DECODE      = 4'd3,
        S_EXEC_ADD_1  = 4'd4,
        S_EXEC_ADD_2  = 4'd5,
        S_EXEC_OR_1   = 4'd6,
        S_EXEC_OR_2   = 4'd7,
        S_EXEC_LOAD_1 = 4'd8,
        S_EXEC_LOAD_2 = 4'd9,
        S_EXEC_STR_1  = 4'd10,
        S_EXEC_STR_2  = 4'd11,
        S_EXEC_JUMP   = 4'd12
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_OR    = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_JUMP  = 4'h5;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    typedef struct packed {
        logic       mar_load;
        logic       mar_sel;
        logic       mdr_load;
        logic       mdr_sel;
        logic       mem_rw;
        logic       pc_inc;
        logic       pc_load;
        logic       ir_load;
        logic       acc_load;
        logic [1:0] alu_op;
    } strobes_t;

    // Next-state function; encodings 13-15 and undefined opcodes fall to Fetch_1.
    function automatic state_t f_next(input state_t s, input logic [3:0] op);
        state_t n;
        n = S_FETCH_1;
        case (s)
            S_FETCH_1:     n = S_FETCH_2;
            S_FETCH_2:     n = S_FETCH_3;
            S_FETCH_3:     n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_ADD:   n = S_EXEC_ADD_1;
                    OP_OR:    n = S_EXEC_OR_1;
                    OP_LOAD:  n = S_EXEC_LOAD_1;
                    OP_STORE: n = S_EXEC_STR_1;
                    OP_JUMP:  n = S_EXEC_JUMP;
                    default:  n = S_FETCH_1;
                endcase
            end
            S_EXEC_ADD_1:  n = S_EXEC_ADD_2;
            S_EXEC_OR_1:   n = S_EXEC_OR_2;
            S_EXEC_LOAD_1: n = S_EXEC_LOAD_2;
            S_EXEC_STR_1:  n = S_EXEC_STR_2;
            default:       n = S_FETCH_1;
        endcase
        return n;
    endfunction

    // Moore strobe decode; anything not listed stays 0, alu_op defaults to pass.
    function automatic strobes_t f_decode(input state_t s);
        strobes_t d;
        d = '0;
        d.alu_op = ALU_PASS;
        case (s)
            S_FETCH_1: begin
                d.mar_sel  = 1'b0;
                d.mar_load = 1'b1;
            end
            S_FETCH_2: begin
                d.mem_rw   = 1'b0;
                d.mdr_sel  = 1'b0;
                d.mdr_load = 1'b1;
                d.pc_inc   = 1'b1;
            end
            S_FETCH_3: begin
                d.ir_load  = 1'b1;
            end
            S_DECODE: begin
                d.mar_sel  = 1'b1;
                d.mar_load = 1'b1;
            end
            S_EXEC_ADD_1, S_EXEC_OR_1, S_EXEC_LOAD_1: begin
                d.mdr_sel  = 1'b0;
                d.mdr_load = 1'b1;
            end
            S_EXEC_ADD_2: begin
                d.alu_op   = ALU_ADD;
                d.acc_load = 1'b1;
            end
            S_EXEC_OR_2: begin
                d.alu_op   = ALU_OR;
                d.acc_load = 1'b1;
            end
            S_EXEC_LOAD_2: begin
                d.alu_op   = ALU_PASS;
                d.acc_load = 1'b1;
            end
            S_EXEC_STR_1: begin
                d.mdr_sel  = 1'b1;
                d.mdr_load = 1'b1;
            end
            S_EXEC_STR_2: begin
                d.mem_rw   = 1'b1;
            end
            S_EXEC_JUMP: begin
                d.pc_load  = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t           r_state;
    strobes_t         r_strobes;
    logic [CNT_W-1:0] r_instr_count;
    logic             r_illegal_op;

    state_t           w_next_state;
    logic             w_retire;
    logic             w_illegal;

    // Next state plus retire/illegal events for the current state.
    always_comb begin
        w_next_state = f_next(r_state, bus.opcode);
        w_retire     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_EXEC_ADD_2, S_EXEC_OR_2, S_EXEC_LOAD_2,
            S_EXEC_STR_2, S_EXEC_JUMP: w_retire = 1'b1;
            default:                   w_retire = 1'b0;
        endcase
        // Decode falling back to Fetch_1 means the opcode was undefined.
        if ((r_state == S_DECODE) && (w_next_state == S_FETCH_1)) begin
            w_illegal = 1'b1;
        end
    end

    // FSM state, registered strobes, retire counter and sticky illegal flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_FETCH_1;
            r_strobes     <= f_decode(S_FETCH_1);
            r_instr_count <= '0;
            r_illegal_op  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_strobes <= f_decode(w_next_state);
            if (w_retire) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
            if (w_illegal) begin
                r_illegal_op <= 1'b1;
            end
        end
    end

    assign bus.state_reg   = r_state;
    assign bus.mar_load    = r_strobes.mar_load;
    assign bus.mar_sel     = r_strobes.mar_sel;
    assign bus.mdr_load    = r_strobes.mdr_load;
    assign bus.mdr_sel     = r_strobes.mdr_sel;
    assign bus.mem_rw      = r_strobes.mem_rw;
    assign bus.pc_inc      = r_strobes.pc_inc;
    assign bus.pc_load     = r_strobes.pc_load;
    assign bus.ir_load     = r_strobes.ir_load;
    assign bus.acc_load    = r_strobes.acc_load;
    assign bus.alu_op      = r_strobes.alu_op;
    assign bus.instr_count = r_instr_count;
    assign bus.illegal_op  = r_illegal_op;

endmodule

// File: tb/tb_proj1_ctrl.sv
// tb_proj1_ctrl: directed bench for proj1_ctrl. A 16-bit instance drives a
// small behavioural datapath + RAM running a fixed program; a 4-bit counter
// instance runs LOAD continuously to exercise counter wrap.
module tb_proj1_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    proj1_ctrl_if #(.CNT_W(16)) bus16 ();
    proj1_ctrl_if #(.CNT_W(4))  bus4 ();

    proj1_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst),  .bus(bus16));
    proj1_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst4), .bus(bus4));

    // Behavioural datapath and RAM driven by dut16 strobes.
    logic [7:0]  pc, mar;
    logic [15:0] mdr, ir, acc;
    logic [15:0] ram [256];

    assign bus16.opcode = ir[15:12];
    assign bus4.opcode  = 4'h3;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= 8'h00;
            mar <= 8'h00;
            mdr <= 16'h0000;
            ir  <= 16'h0000;
            acc <= 16'h0000;
            ram[8'h00] <= 16'h3010;   // LOAD  [10]
            ram[8'h01] <= 16'h400D;   // STORE [0D]
            ram[8'h02] <= 16'h1011;   // ADD   [11]
            ram[8'h03] <= 16'h2012;   // OR    [12]
            ram[8'h04] <= 16'hA000;   // undefined
            ram[8'h05] <= 16'h5008;   // JUMP  08
            ram[8'h08] <= 16'h1013;   // ADD   [13]
            ram[8'h09] <= 16'h1011;   // ADD   [11]
            ram[8'h0D] <= 16'h0000;
            ram[8'h10] <= 16'h1234;
            ram[8'h11] <= 16'h0001;
            ram[8'h12] <= 16'h0F00;
            ram[8'h13] <= 16'hFFFF;
        end else begin
            if (bus16.mar_load) mar <= bus16.mar_sel ? ir[7:0] : pc;
            if (bus16.mdr_load) mdr <= bus16.mdr_sel ? acc : ram[mar];
            if (bus16.mem_rw)   ram[mar] <= mdr;
            if (bus16.pc_inc)   pc <= pc + 8'd1;
            if (bus16.pc_load)  pc <= ir[7:0];
            if (bus16.ir_load)  ir <= mdr;
            if (bus16.acc_load) begin
                case (bus16.alu_op)
                    2'b00:   acc <= mdr;
                    2'b01:   acc <= acc + mdr;
                    2'b10:   acc <= acc | mdr;
                    default: acc <= acc;
                endcase
            end
        end
    end

    // {mar_load, mar_sel, mdr_load, mdr_sel, mem_rw, pc_inc, pc_load, ir_load, acc_load, alu_op}
    wire [10:0] st16 = {bus16.mar_load, bus16.mar_sel, bus16.mdr_load, bus16.mdr_sel,
                        bus16.mem_rw, bus16.pc_inc, bus16.pc_load, bus16.ir_load,
                        bus16.acc_load, bus16.alu_op};
    wire [10:0] st4  = {bus4.mar_load, bus4.mar_sel, bus4.mdr_load, bus4.mdr_sel,
                        bus4.mem_rw, bus4.pc_inc, bus4.pc_load, bus4.ir_load,
                        bus4.acc_load, bus4.alu_op};

    // Strobe table per state number, written from the control-word table.
    function automatic logic [10:0] exp_st(input logic [3:0] s);
        case (s)
            4'd0:                exp_st = 11'b1_0_0_0_0_0_0_0_0_00;
            4'd1:                exp_st = 11'b0_0_1_0_0_1_0_0_0_00;
            4'd2:                exp_st = 11'b0_0_0_0_0_0_0_1_0_00;
            4'd3:                exp_st = 11'b1_1_0_0_0_0_0_0_0_00;
            4'd4, 4'd6, 4'd8:    exp_st = 11'b0_0_1_0_0_0_0_0_0_00;
            4'd5:                exp_st = 11'b0_0_0_0_0_0_0_0_1_01;
            4'd7:                exp_st = 11'b0_0_0_0_0_0_0_0_1_10;
            4'd9:                exp_st = 11'b0_0_0_0_0_0_0_0_1_00;
            4'd10:               exp_st = 11'b0_0_1_1_0_0_0_0_0_00;
            4'd11:               exp_st = 11'b0_0_0_0_1_0_0_0_0_00;
            4'd12:               exp_st = 11'b0_0_0_0_0_0_1_0_0_00;
            default:             exp_st = 11'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk n states (nibbles of seq, MSB first), checking state and strobes each cycle.
    task automatic check_seq(input bit d4, input int n, input logic [31:0] seq);
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            e = seq[31-4*i -: 4];
            if (d4) begin
                chk($sformatf("state4[%0d]", i), 32'(bus4.state_reg), 32'(e));
                chk($sformatf("strobe4[s%0d]", e), 32'(st4), 32'(exp_st(e)));
            end else begin
                chk($sformatf("state16[%0d]", i), 32'(bus16.state_reg), 32'(e));
                chk($sformatf("strobe16[s%0d]", e), 32'(st16), 32'(exp_st(e)));
            end
            tick();
        end
    endtask

    initial begin
        rst  = 1'b1;
        rst4 = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state: Fetch_1 decode, counters clear.
        chk("rst_state", 32'(bus16.state_reg), 32'd0);
        chk("rst_strobes", 32'(st16), 32'(11'b1_0_0_0_0_0_0_0_0_00));
        chk("rst_count", 32'(bus16.instr_count), 32'd0);
        chk("rst_illegal", 32'(bus16.illegal_op), 32'd0);
        chk("rst4_count", 32'(bus4.instr_count), 32'd0);
        rst = 1'b0;

        // LOAD [10]
        check_seq(1'b0, 6, 32'h0123_8900);
        chk("load_acc", 32'(acc), 32'h1234);
        chk("load_count", 32'(bus16.instr_count), 32'd1);

        // STORE [0D]
        check_seq(1'b0, 6, 32'h0123_AB00);
        chk("store_ram", 32'(ram[8'h0D]), 32'h1234);
        chk("store_count", 32'(bus16.instr_count), 32'd2);

        // ADD [11]
        check_seq(1'b0, 6, 32'h0123_4500);
        chk("add_acc", 32'(acc), 32'h1235);
        chk("add_count", 32'(bus16.instr_count), 32'd3);

        // OR [12]
        check_seq(1'b0, 6, 32'h0123_6700);
        chk("or_acc", 32'(acc), 32'h1F35);
        chk("or_count", 32'(bus16.instr_count), 32'd4);

        // Undefined opcode: 4-cycle NOP, sticky flag, count unchanged.
        check_seq(1'b0, 4, 32'h0123_0000);
        chk("ill_flag", 32'(bus16.illegal_op), 32'd1);
        chk("ill_count", 32'(bus16.instr_count), 32'd4);
        chk("ill_pc", 32'(pc), 32'h05);

        // JUMP 08: 5 cycles.
        check_seq(1'b0, 5, 32'h0123_C000);
        chk("jump_pc", 32'(pc), 32'h08);
        chk("jump_count", 32'(bus16.instr_count), 32'd5);

        // ADD [13]: carry dropped; illegal flag still set.
        check_seq(1'b0, 6, 32'h0123_4500);
        chk("add2_acc", 32'(acc), 32'h1F34);
        chk("add2_count", 32'(bus16.instr_count), 32'd6);
        chk("ill_sticky", 32'(bus16.illegal_op), 32'd1);

        // ADD [11] interrupted by asynchronous reset in ExecADD_2.
        check_seq(1'b0, 5, 32'h0123_4000);
        chk("mid_state", 32'(bus16.state_reg), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_state", 32'(bus16.state_reg), 32'd0);
        chk("async_count", 32'(bus16.instr_count), 32'd0);
        chk("async_illegal", 32'(bus16.illegal_op), 32'd0);
        chk("async_strobes", 32'(st16), 32'(11'b1_0_0_0_0_0_0_0_0_00));
        @(negedge clk);
        rst = 1'b0;

        // Resumes at address 0 (LOAD).
        check_seq(1'b0, 6, 32'h0123_8900);
        chk("resume_acc", 32'(acc), 32'h1234);
        chk("resume_count", 32'(bus16.instr_count), 32'd1);

        // 4-bit counter: 16 LOADs count 1..15 then wrap to 0.
        @(negedge clk);
        rst4 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            check_seq(1'b1, 6, 32'h0123_8900);
            chk($sformatf("count4[%0d]", k), 32'(bus4.instr_count), 32'(k % 16));
        end
        chk("ill4_flag", 32'(bus4.illegal_op), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
